aes_state_fifo: RTL and testbench
=================================

Name: aes_state_fifo

Overview:
- Parametrised successor to the flat 16-byte state register: holds up to DEPTH complete AES state words of NBYTES bytes each.
- Uses valid/ready handshakes on both sides, so datapath stages (SubBytes, ShiftRows, MixColumns, key-expansion, I/O wrapper) can stall independently without losing a block.
- Sits between pipeline stages in the AES256 core.
- Degenerates to a single registered state word when DEPTH=1.

Parameters:
- NBYTES, 16, bytes per state word.
- BYTEW, 8, bits per byte.
- DEPTH, 2, number of state-word entries; legal range 1..8.

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  producer has a state word.
- in_ready  out  1  buffer can accept a word this cycle.
- in_data  in  NBYTES*BYTEW  input state; byte k = bits [k*BYTEW +: BYTEW].
- out_valid  out  1  head entry is available.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  NBYTES*BYTEW  head entry, same byte packing.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset: resetn is synchronous and active-low on clk.
  - While resetn=0 at a clk edge: all storage bytes are set to 8'h00, wr_ptr=rd_ptr=0, count=0.
  - While resetn is low: in_ready=0, out_valid=0, out_data=0.
  - First cycle after release: in_ready=1.
- Push: in_valid && in_ready at a clk edge. Word written to storage[wr_ptr]; wr_ptr advances, wrapping DEPTH-1 -> 0.
- Pop: out_valid && out_ready at a clk edge. rd_ptr advances with the same wrap rule.
- Handshake signals:
  - in_ready = resetn && (count < DEPTH). It does not depend on out_ready, so a full buffer never accepts a word even when a pop happens in the same cycle.
  - out_valid = (count != 0).
  - out_data = storage[rd_ptr] when out_valid; all-zero when empty.
- Latency: a word pushed at edge t is visible on out_data/out_valid after edge t. One cycle, no combinational in->out path.
- Simultaneous push and pop (0 < count < DEPTH): both pointers advance and count is unchanged.
- Empty: a pop cannot occur. out_ready while empty has no effect.
- Full: count=DEPTH, in_ready=0. in_valid is ignored and in_data is not stored.
- DEPTH=1: alternates full/empty. Sustains at most one word every 2 cycles.
- Flush: takes effect at the clk edge where flush=1.
  - Ptrs and count go to 0. Storage contents are not cleared, but out_data reads 0 because the buffer is empty.
  - Flush has priority over a push or pop in the same cycle; that push is discarded.
- Reset mid-operation overrides flush and all handshakes.
- Producer rule: in_data/in_valid must hold stable while in_valid && !in_ready.
  - This is an assertion target for verification, not enforced by the block.
- Count saturates by construction. Overflow or underflow is impossible; the bench asserts 0 <= count <= DEPTH.

Optional Feature:
- Macro: AES_STATE_TRANSPOSE_EN.
- Defined: out_data presents the head entry transposed between column-major and row-major AES layout. Output byte k = stored byte 4*(k%4) + k/4.
  - Purely combinational on the read side; latency unchanged.
  - Only legal with NBYTES=16. An elaboration-time check errors otherwise.
- Undefined: out_data byte k = stored byte k, with no reordering logic present.

Test Plan:
- Reset, then release: resetn=0 for 2 cycles -> count=0, out_valid=0, out_data=0, in_ready=0 during reset and 1 on the first cycle after release.
- Single word, DEPTH=2: push in_data=128'h00112233445566778899aabbccddeeff at edge t -> out_valid=1 with identical out_data after t, count=1. Pop at t+1 -> count=0, out_data=0.
- Fill and back-pressure, DEPTH=2, out_ready=0: push A then B -> count=2, in_ready=0. A third word C held on in_valid is not stored. Drain -> A then B appear in order, then C is accepted.
- Concurrent push/pop at count=1 -> count stays 1 and out_data advances to the next word. Repeat DEPTH+3 times to exercise pointer wrap with no data loss.
- Flush with in_valid=1 at count=2 -> count=0, out_valid=0 next cycle, and the flushed-cycle input is absent from later output.
- With AES_STATE_TRANSPOSE_EN: push 128'h000102...0f (byte k = k) -> out_data byte 1 = 8'h04, byte 4 = 8'h01, byte 15 = 8'h0f. Without the macro -> byte 1 = 8'h01.

Source files
------------

// File: rtl/aes_state_fifo.sv
// Valid/ready buffer holding up to DEPTH complete AES state words between core pipeline stages.
// Optional AES_STATE_TRANSPOSE_EN presents the head word transposed between column- and row-major layout.
module aes_state_fifo #(
  parameter int NBYTES = 16,
  parameter int BYTEW  = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NBYTES*BYTEW-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NBYTES*BYTEW-1:0]    out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int W  = NBYTES * BYTEW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  storage_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;
  logic [W-1:0]  raw_s;
  logic [W-1:0]  head_s;

  if ((DEPTH < 1) || (DEPTH > 8)) begin : g_depth_check
    $error("aes_state_fifo: DEPTH must be in 1..8");
  end

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = p + PW'(1);
    end
  endfunction

  // in_ready deliberately ignores out_ready: a full buffer never accepts even on a same-cycle pop
  assign in_ready  = resetn && (count_r < CW'(DEPTH));
  assign out_valid = resetn && (count_r != '0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign count     = count_r;
  assign raw_s     = storage_r[rd_ptr_r];

`ifdef AES_STATE_TRANSPOSE_EN
  if (NBYTES != 16) begin : g_transpose_check
    $error("aes_state_fifo: AES_STATE_TRANSPOSE_EN requires NBYTES == 16");
  end

  for (genvar k = 0; k < NBYTES; k++) begin : g_transpose
    assign head_s[k*BYTEW +: BYTEW] = raw_s[(4*(k%4) + k/4)*BYTEW +: BYTEW];
  end
`else
  assign head_s = raw_s;
`endif

  assign out_data = out_valid ? head_s : '0;

  // Storage, pointers and occupancy; reset beats flush, flush beats any handshake
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        storage_r[wr_ptr_r] <= in_data;
        wr_ptr_r            <= ptr_next(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_state_fifo.sv
// Scoreboard bench for aes_state_fifo (DEPTH=2): expected words queued on push, compared at the head.
module tb_aes_state_fifo;

  localparam int DEPTH = 2;

  logic         clk;
  logic         resetn;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [1:0]   count;

  int checks;
  int failures;
  logic [127:0] q[$];
  logic [127:0] seq_word;
  logic [127:0] byte_word;

  aes_state_fifo #(.NBYTES(16), .BYTEW(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] xform(input logic [127:0] v);
    logic [127:0] r;
`ifdef AES_STATE_TRANSPOSE_EN
    for (int k = 0; k < 16; k++) begin
      r[k*8 +: 8] = v[(4*(k%4) + k/4)*8 +: 8];
    end
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, clock, update the model
  task automatic step(input logic iv, input logic [127:0] d, input logic ordy, input logic fl);
    logic push_now;
    logic pop_now;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_val("count", {126'd0, count}, 128'(q.size()));
    check_val("in_ready", {127'd0, in_ready}, {127'd0, (q.size() < DEPTH)});
    check_val("out_valid", {127'd0, out_valid}, {127'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      check_val("out_data", out_data, xform(q[0]));
    end else begin
      check_val("out_data_empty", out_data, 128'd0);
    end
    push_now = iv && (q.size() < DEPTH);
    pop_now  = ordy && (q.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (pop_now) void'(q.pop_front());
      if (push_now) q.push_back(d);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 128'd0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_count", {126'd0, count}, 128'd0);
    check_val("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_val("rst_out_data", out_data, 128'd0);
    check_val("rst_in_ready", {127'd0, in_ready}, 128'd0);
    resetn = 1'b1;
    #1;
    check_val("rel_in_ready", {127'd0, in_ready}, 128'd1);

    // Single word round trip
    step(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0);
    step(1'b0, 128'd0, 1'b1, 1'b0);
    step(1'b0, 128'd0, 1'b0, 1'b0);

    // Fill, back-pressure with C held, then drain
    step(1'b1, 128'hA, 1'b0, 1'b0);
    step(1'b1, 128'hB, 1'b0, 1'b0);
    step(1'b1, 128'hC, 1'b0, 1'b0);
    step(1'b1, 128'hC, 1'b0, 1'b0);
    step(1'b1, 128'hC, 1'b1, 1'b0);
    step(1'b1, 128'hC, 1'b1, 1'b0);
    step(1'b0, 128'd0, 1'b1, 1'b0);
    step(1'b0, 128'd0, 1'b0, 1'b0);

    // Concurrent push/pop at count=1 across several pointer wraps
    step(1'b1, 128'h1000, 1'b0, 1'b0);
    for (int i = 1; i <= DEPTH + 3; i++) begin
      seq_word = 128'h1000 + 128'(i);
      step(1'b1, seq_word, 1'b1, 1'b0);
    end
    step(1'b0, 128'd0, 1'b1, 1'b0);
    step(1'b0, 128'd0, 1'b0, 1'b0);

    // Flush at full with a competing push; flushed input must never appear
    step(1'b1, 128'hD1, 1'b0, 1'b0);
    step(1'b1, 128'hD2, 1'b0, 1'b0);
    step(1'b1, 128'hF1F1, 1'b1, 1'b1);
    step(1'b0, 128'd0, 1'b1, 1'b0);
    step(1'b1, 128'hE1, 1'b0, 1'b0);
    step(1'b0, 128'd0, 1'b1, 1'b0);
    step(1'b0, 128'd0, 1'b0, 1'b0);

    // Byte-index pattern for layout check
    for (int k = 0; k < 16; k++) begin
      byte_word[k*8 +: 8] = 8'(k);
    end
    step(1'b1, byte_word, 1'b0, 1'b0);
    #1;
`ifdef AES_STATE_TRANSPOSE_EN
    check_val("tr_byte1", {120'd0, out_data[15:8]}, 128'h04);
    check_val("tr_byte4", {120'd0, out_data[39:32]}, 128'h01);
    check_val("tr_byte15", {120'd0, out_data[127:120]}, 128'h0f);
`else
    check_val("id_byte1", {120'd0, out_data[15:8]}, 128'h01);
    check_val("id_byte15", {120'd0, out_data[127:120]}, 128'h0f);
`endif
    step(1'b0, 128'd0, 1'b1, 1'b0);

    // Reset in the middle of traffic
    step(1'b1, 128'h77, 1'b0, 1'b0);
    resetn   = 1'b0;
    in_valid = 1'b1;
    in_data  = 128'h88;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    check_val("mid_rst_count", {126'd0, count}, 128'd0);
    check_val("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
    check_val("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    resetn = 1'b1;
    step(1'b0, 128'd0, 1'b0, 1'b0);
    step(1'b1, 128'h99, 1'b0, 1'b0);
    step(1'b0, 128'd0, 1'b1, 1'b0);
    step(1'b0, 128'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
